// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vend dispense actuator driver.
//   - vend result code constants from the coin-counting FSM
//   - dispense FSM state enum
//   - max_of3 helper used to size the shared down-counter
package vend_pkg;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_VEND     = 2'b01;
  localparam logic [1:0] CODE_VEND_CHG = 2'b10;
  localparam logic [1:0] CODE_REFUND   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VEND_ON,
    ST_VEND_GAP,
    ST_COIN_ON,
    ST_COIN_WAIT,
    ST_DONE,
    ST_FAULT
  } state_e;

  function automatic int unsigned max_of3(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/vend_dispense_sync_rise.sv
// sync_rise: two-flop synchronizer for an asynchronous level input plus a
// registered rising-edge detector. Reusable on the key input path.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset, clears all flops to 0
//   d_i    in  raw asynchronous level
//   rise_o out one-cycle pulse per rising edge of d_i
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, rise_q;

  // The edge is taken between the two synchronizer stages, so a raw sample
  // captured at edge E appears on rise_o after E+1 and is consumed at E+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      rise_q <= s1_q & ~s2_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/vend_dispense.sv
// vend_dispense: turns a settled vend result code into timed drive pulses
// for the product solenoid and the coin hopper, waits for the hopper's
// coin-out acknowledge and raises a sticky fault if it never arrives.
// Ports:
//   clk          in  system clock
//   rst          in  synchronous active-high reset
//   vend_valid   in  one-cycle strobe qualifying vend_code
//   vend_code    in  00 none, 01 product, 10 product + change, 11 refund
//   hopper_ack   in  raw asynchronous coin-out sensor, active high
//   motor_pulse  out product solenoid drive
//   hopper_pulse out coin hopper drive
//   busy         out high whenever not idle (including fault)
//   done         out one-cycle completion strobe
//   fault        out sticky hopper acknowledge timeout
module vend_dispense
  import vend_pkg::*;
#(
  parameter int unsigned PULSE_CYC       = 2_500_000,
  parameter int unsigned GAP_CYC         = 2_500_000,
  parameter int unsigned ACK_TIMEOUT_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_valid,
  input  logic [1:0] vend_code,
  input  logic       hopper_ack,
  output logic       motor_pulse,
  output logic       hopper_pulse,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int unsigned CNT_W =
    $clog2(max_of3(PULSE_CYC, GAP_CYC, ACK_TIMEOUT_CYC)) + 1;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LD   = CNT_W'(ACK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic             ack_seen_q, ack_seen_d;
  logic             ack_rise;
  logic             motor_q, hopper_q, busy_q, done_q, fault_q;

  sync_rise u_ack_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (hopper_ack),
    .rise_o (ack_rise)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    ack_seen_d = ack_seen_q;

    unique case (state_q)
      ST_IDLE: begin
        if (vend_valid) begin
          if (vend_code == CODE_VEND || vend_code == CODE_VEND_CHG) begin
            state_d = ST_VEND_ON;
            cnt_d   = PULSE_LD;
            code_d  = vend_code;
          end else if (vend_code == CODE_REFUND) begin
            state_d    = ST_COIN_ON;
            cnt_d      = PULSE_LD;
            code_d     = vend_code;
            ack_seen_d = 1'b0;
          end
        end
      end

      ST_VEND_ON: begin
        if (cnt_q == '0) begin
          state_d = ST_VEND_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_VEND_GAP: begin
        if (cnt_q == '0) begin
          if (code_q == CODE_VEND_CHG) begin
            state_d    = ST_COIN_ON;
            cnt_d      = PULSE_LD;
            ack_seen_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_COIN_ON: begin
        // An ack edge during the drive pulse is remembered so the wait
        // state can complete on its first cycle.
        ack_seen_d = ack_seen_q | ack_rise;
        if (cnt_q == '0) begin
          state_d = ST_COIN_WAIT;
          cnt_d   = ACK_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_COIN_WAIT: begin
        if (ack_seen_q || ack_rise) begin
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DONE:  state_d = ST_IDLE;

      ST_FAULT: state_d = ST_FAULT;

      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      code_q     <= CODE_NONE;
      ack_seen_q <= 1'b0;
      motor_q    <= 1'b0;
      hopper_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      ack_seen_q <= ack_seen_d;
      // Outputs are registered from the next state so they line up with
      // the state they describe.
      motor_q    <= (state_d == ST_VEND_ON);
      hopper_q   <= (state_d == ST_COIN_ON);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  assign motor_pulse  = motor_q;
  assign hopper_pulse = hopper_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;

endmodule
